coder_axil_regbank: RTL and testbench

//  Parametrised AXI4-Lite slave register bank for the coder IP; successor to the fixed
//  4 x 32-bit slave. Generalises register count and width. Adds byte strobes,
//  per-register read-only (hardware-status) mapping and SLVERR for unmapped or RO writes.

---
 rtl/coder_axil_pkg.sv | 16 +
 rtl/coder_axil_wr_ctrl.sv | 102 ++++++++++
 rtl/coder_axil_regbank.sv | 172 +++++++++++++++++
 tb/tb_coder_axil_regbank.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coder_axil_pkg.sv
// Shared response codes, FSM state types and address decode helper for the
// coder AXI4-Lite register bank.
package coder_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_RESP} rd_state_t;

   // Register index of a byte address; lsb = log2(bytes per register).
   function automatic logic [31:0] idx_of(input logic [63:0] addr, input int lsb);
      return 32'(addr >> lsb);
   endfunction

endpackage

// File: rtl/coder_axil_wr_ctrl.sv
// AXI4-Lite write-channel controller: accepts AW and W in any order, latches
// them, and emits a single-cycle commit carrying the merged address/data/strobe.
module coder_axil_wr_ctrl
   import coder_axil_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 6
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [ADDR_W-1:0]   i_awaddr,
   input  logic                i_awvalid,
   output logic                o_awready,
   input  logic [DATA_W-1:0]   i_wdata,
   input  logic [DATA_W/8-1:0] i_wstrb,
   input  logic                i_wvalid,
   output logic                o_wready,
   output logic [1:0]          o_bresp,
   output logic                o_bvalid,
   input  logic                i_bready,
   input  logic                i_err,
   output logic                o_commit,
   output logic [ADDR_W-1:0]   o_addr,
   output logic [DATA_W-1:0]   o_data,
   output logic [DATA_W/8-1:0] o_strb
);

   wr_state_t             r_state;
   wr_state_t             w_next;
   logic                  r_live;
   logic [ADDR_W-1:0]     r_awaddr;
   logic [DATA_W-1:0]     r_wdata;
   logic [DATA_W/8-1:0]   r_wstrb;
   logic [1:0]            r_bresp;
   logic                  w_aw_hs;
   logic                  w_w_hs;

   // r_live holds the readies low while reset is asserted and for one edge after.
   assign o_awready = r_live && (r_state == W_IDLE || r_state == W_GOT_W);
   assign o_wready  = r_live && (r_state == W_IDLE || r_state == W_GOT_AW);
   assign w_aw_hs   = i_awvalid && o_awready;
   assign w_w_hs    = i_wvalid && o_wready;
   assign o_bvalid  = (r_state == W_RESP);
   assign o_bresp   = r_bresp;

   // A handshake in the commit cycle bypasses its latch.
   assign o_addr = w_aw_hs ? i_awaddr : r_awaddr;
   assign o_data = w_w_hs  ? i_wdata  : r_wdata;
   assign o_strb = w_w_hs  ? i_wstrb  : r_wstrb;

   always_comb begin
      w_next   = r_state;
      o_commit = 1'b0;
      unique case (r_state)
         W_IDLE: begin
            if (w_aw_hs && w_w_hs) begin
               o_commit = 1'b1;
               w_next   = W_RESP;
            end else if (w_aw_hs) begin
               w_next = W_GOT_AW;
            end else if (w_w_hs) begin
               w_next = W_GOT_W;
            end
         end
         W_GOT_AW: begin
            if (w_w_hs) begin
               o_commit = 1'b1;
               w_next   = W_RESP;
            end
         end
         W_GOT_W: begin
            if (w_aw_hs) begin
               o_commit = 1'b1;
               w_next   = W_RESP;
            end
         end
         W_RESP:  if (i_bready) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= W_IDLE;
         r_live   <= 1'b0;
         r_awaddr <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_bresp  <= RESP_OKAY;
      end else begin
         r_live  <= 1'b1;
         r_state <= w_next;
         if (w_aw_hs) r_awaddr <= i_awaddr;
         if (w_w_hs) begin
            r_wdata <= i_wdata;
            r_wstrb <= i_wstrb;
         end
         if (o_commit) r_bresp <= i_err ? RESP_SLVERR : RESP_OKAY;
      end
   end

endmodule

// File: rtl/coder_axil_regbank.sv
// Parametrised AXI4-Lite register bank for the coder IP: byte-strobed RW
// registers, read-only status mapping, SLVERR decode and per-register strobes.
module coder_axil_regbank
   import coder_axil_pkg::*;
#(
   parameter int                         DATA_W    = 32,
   parameter int                         NUM_REGS  = 8,
   parameter int                         ADDR_W    = 6,
   parameter logic [NUM_REGS-1:0]        RO_MASK   = '0,
   parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                         ACLK,
   input  logic                         ARESETN,
   input  logic [ADDR_W-1:0]            S_AXI_AWADDR,
   input  logic [2:0]                   S_AXI_AWPROT,
   input  logic                         S_AXI_AWVALID,
   output logic                         S_AXI_AWREADY,
   input  logic [DATA_W-1:0]            S_AXI_WDATA,
   input  logic [DATA_W/8-1:0]          S_AXI_WSTRB,
   input  logic                         S_AXI_WVALID,
   output logic                         S_AXI_WREADY,
   output logic [1:0]                   S_AXI_BRESP,
   output logic                         S_AXI_BVALID,
   input  logic                         S_AXI_BREADY,
   input  logic [ADDR_W-1:0]            S_AXI_ARADDR,
   input  logic [2:0]                   S_AXI_ARPROT,
   input  logic                         S_AXI_ARVALID,
   output logic                         S_AXI_ARREADY,
   output logic [DATA_W-1:0]            S_AXI_RDATA,
   output logic [1:0]                   S_AXI_RRESP,
   output logic                         S_AXI_RVALID,
   input  logic                         S_AXI_RREADY,
   output logic [NUM_REGS*DATA_W-1:0]   reg_out,
   input  logic [NUM_REGS*DATA_W-1:0]   reg_in,
   output logic [NUM_REGS-1:0]          wr_pulse,
   output logic [NUM_REGS-1:0]          rd_pulse
);

   localparam int          STRB_W = DATA_W / 8;
   localparam int          LSB    = $clog2(STRB_W);
   localparam int          IW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [31:0] NREG   = NUM_REGS;

   function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] res;
      res = old_v;
      for (int b = 0; b < STRB_W; b++)
         if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
      return res;
   endfunction

   logic [DATA_W-1:0]   r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_wr_pulse;
   logic [NUM_REGS-1:0] r_rd_pulse;
   logic [DATA_W-1:0]   r_rdata;
   logic [1:0]          r_rresp;
   logic                r_live;
   rd_state_t           r_rstate;
   rd_state_t           w_rnext;

   logic                w_commit;
   logic [ADDR_W-1:0]   w_waddr;
   logic [DATA_W-1:0]   w_wdata;
   logic [STRB_W-1:0]   w_wstrb;
   logic [31:0]         w_widx;
   logic [IW-1:0]       w_wsel;
   logic                w_wok;
   logic [31:0]         w_ridx;
   logic [IW-1:0]       w_rsel;
   logic                w_rok;
   logic [DATA_W-1:0]   w_rd_val;
   logic                w_ar_hs;
   logic                w_unused;

   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   coder_axil_wr_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wr_ctrl (
      .i_clk     (ACLK),
      .i_rst_n   (ARESETN),
      .i_awaddr  (S_AXI_AWADDR),
      .i_awvalid (S_AXI_AWVALID),
      .o_awready (S_AXI_AWREADY),
      .i_wdata   (S_AXI_WDATA),
      .i_wstrb   (S_AXI_WSTRB),
      .i_wvalid  (S_AXI_WVALID),
      .o_wready  (S_AXI_WREADY),
      .o_bresp   (S_AXI_BRESP),
      .o_bvalid  (S_AXI_BVALID),
      .i_bready  (S_AXI_BREADY),
      .i_err     (!w_wok),
      .o_commit  (w_commit),
      .o_addr    (w_waddr),
      .o_data    (w_wdata),
      .o_strb    (w_wstrb)
   );

   assign w_widx = idx_of(64'(w_waddr), LSB);
   assign w_wsel = w_widx[IW-1:0];
   assign w_ridx = idx_of(64'(S_AXI_ARADDR), LSB);
   assign w_rsel = w_ridx[IW-1:0];

   always_comb begin
      w_wok = 1'b0;
      if (w_widx < NREG) w_wok = !RO_MASK[w_wsel];
   end

   always_comb begin
      w_rok    = 1'b0;
      w_rd_val = '0;
      if (w_ridx < NREG) begin
         w_rok    = 1'b1;
         w_rd_val = RO_MASK[w_rsel] ? reg_in[int'(w_rsel)*DATA_W +: DATA_W] : r_regs[w_rsel];
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL[i*DATA_W +: DATA_W];
         r_wr_pulse <= '0;
      end else begin
         r_wr_pulse <= '0;
         if (w_commit && w_wok) begin
            r_regs[w_wsel]     <= byte_merge(r_regs[w_wsel], w_wdata, w_wstrb);
            r_wr_pulse[w_wsel] <= 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign reg_out[g*DATA_W +: DATA_W] = r_regs[g];
   end

   assign wr_pulse      = r_wr_pulse;
   assign rd_pulse      = r_rd_pulse;
   assign S_AXI_ARREADY = r_live && (r_rstate == R_IDLE);
   assign S_AXI_RVALID  = (r_rstate == R_RESP);
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = r_rresp;
   assign w_ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;

   always_comb begin
      w_rnext = r_rstate;
      unique case (r_rstate)
         R_IDLE:  if (w_ar_hs) w_rnext = R_RESP;
         R_RESP:  if (S_AXI_RREADY) w_rnext = R_IDLE;
         default: w_rnext = R_IDLE;
      endcase
   end

   // Read data samples the pre-commit register value on a same-edge write.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_rstate   <= R_IDLE;
         r_live     <= 1'b0;
         r_rdata    <= '0;
         r_rresp    <= RESP_OKAY;
         r_rd_pulse <= '0;
      end else begin
         r_live     <= 1'b1;
         r_rstate   <= w_rnext;
         r_rd_pulse <= '0;
         if (w_ar_hs) begin
            r_rdata <= w_rd_val;
            r_rresp <= w_rok ? RESP_OKAY : RESP_SLVERR;
            if (w_rok) r_rd_pulse[w_rsel] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_coder_axil_regbank.sv
// Directed scoreboard bench for coder_axil_regbank (32-bit, 8 regs, reg 7 read-only).
module tb_coder_axil_regbank;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [7:0] RO     = 8'h80;

   logic         ACLK, ARESETN;
   logic [5:0]   S_AXI_AWADDR, S_AXI_ARADDR;
   logic [2:0]   S_AXI_AWPROT, S_AXI_ARPROT;
   logic         S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
   logic [31:0]  S_AXI_WDATA, S_AXI_RDATA;
   logic [3:0]   S_AXI_WSTRB;
   logic [1:0]   S_AXI_BRESP, S_AXI_RRESP;
   logic         S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
   logic         S_AXI_RVALID, S_AXI_RREADY;
   logic [255:0] reg_out, reg_in;
   logic [7:0]   wr_pulse, rd_pulse;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic [7:0]  pulse;
   } exp_t;

   exp_t        wq[$];
   exp_t        rq[$];
   logic [31:0] m_regs [8];
   int          total = 0;
   int          bad   = 0;

   coder_axil_regbank #(
      .DATA_W(32), .NUM_REGS(8), .ADDR_W(6), .RO_MASK(RO), .RESET_VAL('0)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Drives W immediately and AW after aw_delay cycles; pushes the expected B response.
   task automatic do_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_delay);
      exp_t       e;
      logic [3:0] idx;
      bit         aw_done, w_done, aw_take, w_take;
      int         n;
      idx = addr[5:2];
      if (idx < 4'd8 && !RO[idx[2:0]]) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) m_regs[idx[2:0]][8*b +: 8] = data[8*b +: 8];
         e.resp  = OKAY;
         e.pulse = 8'h1 << idx[2:0];
      end else begin
         e.resp  = SLVERR;
         e.pulse = 8'h0;
      end
      e.data = '0;
      wq.push_back(e);
      S_AXI_WDATA  = data;
      S_AXI_WSTRB  = strb;
      S_AXI_WVALID = 1'b1;
      aw_done = 0;
      w_done  = 0;
      n       = 0;
      while (!(aw_done && w_done)) begin
         if (!aw_done && n >= aw_delay) begin
            S_AXI_AWADDR  = addr;
            S_AXI_AWVALID = 1'b1;
         end
         aw_take = S_AXI_AWVALID && S_AXI_AWREADY;
         w_take  = S_AXI_WVALID && S_AXI_WREADY;
         @(negedge ACLK);
         n++;
         if (aw_take) begin S_AXI_AWVALID = 1'b0; aw_done = 1; end
         if (w_take)  begin S_AXI_WVALID  = 1'b0; w_done  = 1; end
         if (n > 60) begin
            check("wr_handshake_timeout", {62'd0, aw_done, w_done}, 64'd3);
            S_AXI_AWVALID = 1'b0;
            S_AXI_WVALID  = 1'b0;
            break;
         end
      end
      check("bvalid_latency", S_AXI_BVALID, 1);
   endtask

   task automatic collect_b(input int hold);
      exp_t e;
      int   n;
      n = 0;
      while (!S_AXI_BVALID && n < 20) begin @(negedge ACLK); n++; end
      check("bvalid_seen", S_AXI_BVALID, 1);
      check("b_scoreboard_nonempty", wq.size() != 0, 1);
      if (wq.size() != 0) begin
         e = wq.pop_front();
         check("bresp", S_AXI_BRESP, e.resp);
         check("wr_pulse", wr_pulse, e.pulse);
         for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            check("bvalid_hold", S_AXI_BVALID, 1);
            check("bresp_hold", S_AXI_BRESP, e.resp);
            check("awready_hold", S_AXI_AWREADY, 0);
            check("wready_hold", S_AXI_WREADY, 0);
         end
      end
      S_AXI_BREADY = 1'b1;
      @(negedge ACLK);
      S_AXI_BREADY = 1'b0;
      check("bvalid_drop", S_AXI_BVALID, 0);
      check("wr_pulse_clear", wr_pulse, 0);
   endtask

   task automatic do_read(input logic [5:0] addr);
      exp_t       e;
      logic [3:0] idx;
      bit         take;
      int         n;
      idx = addr[5:2];
      if (idx < 4'd8) begin
         e.data  = RO[idx[2:0]] ? reg_in[idx[2:0]*32 +: 32] : m_regs[idx[2:0]];
         e.resp  = OKAY;
         e.pulse = 8'h1 << idx[2:0];
      end else begin
         e.data  = '0;
         e.resp  = SLVERR;
         e.pulse = 8'h0;
      end
      rq.push_back(e);
      S_AXI_ARADDR  = addr;
      S_AXI_ARVALID = 1'b1;
      n = 0;
      take = 0;
      while (!take && n < 60) begin
         take = S_AXI_ARREADY;
         @(negedge ACLK);
         n++;
      end
      S_AXI_ARVALID = 1'b0;
      check("rd_handshake", take, 1);
      check("rvalid_latency", S_AXI_RVALID, 1);
   endtask

   task automatic collect_r(input int hold);
      exp_t e;
      int   n;
      n = 0;
      while (!S_AXI_RVALID && n < 20) begin @(negedge ACLK); n++; end
      check("rvalid_seen", S_AXI_RVALID, 1);
      check("r_scoreboard_nonempty", rq.size() != 0, 1);
      if (rq.size() != 0) begin
         e = rq.pop_front();
         check("rdata", S_AXI_RDATA, e.data);
         check("rresp", S_AXI_RRESP, e.resp);
         check("rd_pulse", rd_pulse, e.pulse);
         for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            check("rvalid_hold", S_AXI_RVALID, 1);
            check("rdata_hold", S_AXI_RDATA, e.data);
            check("rresp_hold", S_AXI_RRESP, e.resp);
            check("arready_hold", S_AXI_ARREADY, 0);
         end
      end
      S_AXI_RREADY = 1'b1;
      @(negedge ACLK);
      S_AXI_RREADY = 1'b0;
      check("rvalid_drop", S_AXI_RVALID, 0);
      check("rd_pulse_clear", rd_pulse, 0);
   endtask

   initial begin
      ARESETN = 1'b0;
      S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = '0;  S_AXI_WSTRB = '0;  S_AXI_WVALID = 1'b0;
      S_AXI_BREADY = 1'b0;
      S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY = 1'b0;
      reg_in = {32'hDEADBEEF, 32'h0BAD0006, 32'h0BAD0005, 32'h0BAD0004,
                32'h0BAD0003, 32'h0BAD0002, 32'h0BAD0001, 32'h0BAD0000};
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      repeat (2) @(negedge ACLK);

      // reset state
      check("rst_awready", S_AXI_AWREADY, 0);
      check("rst_wready", S_AXI_WREADY, 0);
      check("rst_arready", S_AXI_ARREADY, 0);
      check("rst_bvalid", S_AXI_BVALID, 0);
      check("rst_rvalid", S_AXI_RVALID, 0);
      check("rst_resp", {S_AXI_BRESP, S_AXI_RRESP}, 0);
      check("rst_rdata", S_AXI_RDATA, 0);
      check("rst_pulses", {wr_pulse, rd_pulse}, 0);
      check("rst_reg_out", reg_out[63:0], 0);
      check("rst_reg_out_hi", reg_out[255:192], 0);
      ARESETN = 1'b1;
      repeat (2) @(negedge ACLK);

      // 1: basic writes and read-back
      for (int i = 0; i < 4; i++) begin
         do_write(6'(i * 4), 32'(i + 1), 4'hF, 0);
         collect_b(0);
      end
      for (int i = 0; i < 4; i++) begin
         do_read(6'(i * 4));
         collect_r(0);
      end

      // 2: W leads AW by 3 cycles, partial strobes
      do_write(6'h10, 32'h11223344, 4'hF, 0);
      collect_b(0);
      do_write(6'h10, 32'hAABBCCDD, 4'b0101, 3);
      collect_b(0);
      check("reg4_merge", reg_out[4*32 +: 32], 32'h11BB33DD);
      do_read(6'h10);
      collect_r(0);

      // 3: read-only register
      do_write(6'h1C, 32'h12345678, 4'hF, 0);
      collect_b(0);
      check("reg7_unchanged", reg_out[7*32 +: 32], 32'h0);
      do_read(6'h1C);
      collect_r(0);

      // 4: unmapped address
      do_write(6'h20, 32'h87654321, 4'hF, 1);
      collect_b(0);
      do_read(6'h20);
      collect_r(0);

      // 5: back-pressure on B and R
      do_write(6'h04, 32'hCAFEF00D, 4'hF, 0);
      collect_b(10);
      do_read(6'h04);
      collect_r(10);

      // 6: reset while a write response is pending
      do_write(6'h08, 32'h00000055, 4'hF, 0);
      check("reg2_before_reset", reg_out[2*32 +: 32], 32'h55);
      #2 ARESETN = 1'b0;
      #1;
      check("rst_mid_bvalid", S_AXI_BVALID, 0);
      check("rst_mid_reg2", reg_out[2*32 +: 32], 32'h0);
      wq.delete();
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      @(negedge ACLK);
      ARESETN = 1'b1;
      S_AXI_BREADY = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge ACLK);
         check("no_b_after_reset", S_AXI_BVALID, 0);
      end
      S_AXI_BREADY = 1'b0;
      do_read(6'h08);
      collect_r(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
